// File: rtl/systolic_pe_mp.sv
// Multi-precision systolic PE with a Depth-entry weight bank.
// Define SYSTOLIC_PE_SAT_EN for saturating accumulation with overflow flag.
module systolic_pe_mp #(
  parameter int BitSize       = 8,
  parameter int M_W_BitSize   = 8,
  parameter int Depth         = 4,
  parameter int Offset        = 0,
  parameter int FixedPointPos = 0
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   in_valid,
  input  logic [1:0]             in_mode,
  input  logic                   en_l_b,
  input  logic                   in_increment,
  input  logic [BitSize-1:0]     in_a,
  input  logic [M_W_BitSize-1:0] in_b,
  input  logic [BitSize-1:0]     in_partial_sum,
  output logic                   out_valid,
  output logic [1:0]             out_mode,
  output logic                   out_increment,
  output logic [BitSize-1:0]     out_a,
  output logic [M_W_BitSize-1:0] out_b,
  output logic                   out_l_b,
  output logic [BitSize-1:0]     out_partial_sum,
  output logic                   out_overflow
);

  localparam int PW = BitSize + 8;
  localparam int SW = BitSize + 9;
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW-1:0] RD_RST = AW'(Offset % Depth);
  localparam logic [AW-1:0] LAST   = AW'(Depth - 1);

  logic [7:0]         bank_q [Depth];
  logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic               valid_q, inc_q, lb_q, ovf_q;
  logic [1:0]         mode_q;
  logic [BitSize-1:0] a_q, ps_q;
  logic [M_W_BitSize-1:0] b_q;

  logic [7:0]           w;
  logic signed [PW-1:0] a_x, w4_x, w8_x, mul4, mul8, prod;
  logic signed [SW-1:0] sum;
  logic [BitSize-1:0]   red;
  logic                 ovf;

  assign w    = bank_q[rd_q];
  assign a_x  = {{8{in_a[BitSize-1]}}, in_a};
  assign w4_x = {{(PW-4){w[3]}}, w[3:0]};
  assign w8_x = {{(PW-8){w[7]}}, w};
  assign mul4 = (a_x * w4_x) >>> FixedPointPos;
  assign mul8 = (a_x * w8_x) >>> FixedPointPos;

  always_comb begin
    prod = '0;
    unique case (in_mode)
      2'd0: prod = w[0] ? a_x : -a_x;
      2'd1: begin
        if (w[1:0] == 2'b01)      prod = a_x;
        else if (w[1:0] == 2'b11) prod = -a_x;
        else                      prod = '0;
      end
      2'd2: prod = mul4;
      2'd3: prod = mul8;
    endcase
  end

  assign sum = {{9{in_partial_sum[BitSize-1]}}, in_partial_sum}
             + {prod[PW-1], prod};

`ifdef SYSTOLIC_PE_SAT_EN
  // Upper bits must all match the result sign bit to fit in BitSize.
  logic [SW-BitSize:0] hi;
  assign hi  = sum[SW-1:BitSize-1];
  assign ovf = !((&hi) || !(|hi));
  assign red = !ovf ? sum[BitSize-1:0]
             : sum[SW-1] ? {1'b1, {(BitSize-1){1'b0}}}
             : {1'b0, {(BitSize-1){1'b1}}};
`else
  assign ovf = 1'b0;
  assign red = sum[BitSize-1:0];
`endif

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (en_l_b)
      wr_d = (wr_q == LAST) ? '0 : wr_q + 1'b1;
    if (in_valid && in_increment)
      rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < Depth; i++) bank_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= RD_RST;
      valid_q <= 1'b0;
      mode_q  <= '0;
      inc_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      lb_q    <= 1'b0;
      ps_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      b_q     <= in_b;
      lb_q    <= en_l_b;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      if (en_l_b) bank_q[wr_q] <= in_b[7:0];
      if (in_valid) begin
        mode_q <= in_mode;
        inc_q  <= in_increment;
        a_q    <= in_a;
        ps_q   <= red;
        ovf_q  <= ovf;
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_mode        = mode_q;
  assign out_increment   = inc_q;
  assign out_a           = a_q;
  assign out_b           = b_q;
  assign out_l_b         = lb_q;
  assign out_partial_sum = ps_q;
  assign out_overflow    = ovf_q;

endmodule

// File: tb/tb_systolic_pe_mp.sv
// Directed self-checking bench for systolic_pe_mp.
// Expected values are hand-computed for BitSize=8, Depth=4.
module tb_systolic_pe_mp;
  logic       clk = 1'b0;
  logic       res, in_valid, en_l_b, in_increment;
  logic [1:0] in_mode;
  logic [7:0] in_a, in_b, in_partial_sum;
  logic       out_valid, out_increment, out_l_b, out_overflow;
  logic [1:0] out_mode;
  logic [7:0] out_a, out_b, out_partial_sum;
  int n_asr  = 0;
  int n_fail = 0;

  systolic_pe_mp dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_mode(in_mode),
    .en_l_b(en_l_b), .in_increment(in_increment), .in_a(in_a),
    .in_b(in_b), .in_partial_sum(in_partial_sum),
    .out_valid(out_valid), .out_mode(out_mode),
    .out_increment(out_increment), .out_a(out_a), .out_b(out_b),
    .out_l_b(out_l_b), .out_partial_sum(out_partial_sum),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    res = 0; in_valid = 0; en_l_b = 0; in_increment = 0;
    in_mode = 0; in_a = 0; in_b = 0; in_partial_sum = 0;
  endtask

  task automatic load(logic [7:0] v);
    idle(); en_l_b = 1; in_b = v;
    step();
  endtask

  task automatic beat(logic [1:0] m, logic [7:0] a,
                      logic [7:0] ps, logic inc);
    idle(); in_valid = 1; in_mode = m;
    in_a = a; in_partial_sum = ps; in_increment = inc;
    step();
  endtask

  task automatic do_reset();
    idle(); res = 1;
    step();
    res = 0;
  endtask

  initial begin
    idle();
    #1;
    // reset held 2 cycles against a concurrent load and beat
    res = 1; in_valid = 1; en_l_b = 1; in_b = 8'h55;
    in_a = 8'd5; in_partial_sum = 8'd3; in_mode = 2'd3;
    in_increment = 1;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_ps", out_partial_sum, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_lb", out_l_b, 0);
    chk("rst_mode", out_mode, 0);
    chk("rst_inc", out_increment, 0);
    chk("rst_ovf", out_overflow, 0);

    // first beat after release: bank cleared, so ps passes through
    beat(2'd3, 8'd5, 8'd7, 1'b0);
    chk("first_valid", out_valid, 1);
    chk("first_ps", out_partial_sum, 8'd7);
    idle();
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_hold", out_partial_sum, 8'd7);

    // 8-bit mode
    load(8'h03);
    chk("pass_lb", out_l_b, 1);
    chk("pass_b", out_b, 8'h03);
    beat(2'd3, 8'd5, 8'd10, 1'b0);
    chk("m3_valid", out_valid, 1);
    chk("m3_ps", out_partial_sum, 8'd25);
    chk("m3_a", out_a, 8'd5);
    chk("m3_mode", out_mode, 2'd3);

    // low precision modes
    do_reset();
    load(8'h03); load(8'h02); load(8'h00);
    beat(2'd1, 8'd7, 8'd0, 1'b1);
    chk("m1_neg", out_partial_sum, 8'hF9);
    beat(2'd1, 8'd7, 8'd0, 1'b1);
    chk("m1_zero", out_partial_sum, 8'h00);
    beat(2'd0, 8'd3, 8'd0, 1'b1);
    chk("m0_neg", out_partial_sum, 8'hFD);
    chk("m0_inc", out_increment, 1);
    chk("m0_mode", out_mode, 2'd0);

    // read pointer wraps after Depth entries
    do_reset();
    load(8'd1); load(8'd2); load(8'd3); load(8'd4);
    beat(2'd3, 8'd1, 8'd0, 1'b1);
    chk("wrap0", out_partial_sum, 8'd1);
    beat(2'd3, 8'd1, 8'd0, 1'b1);
    chk("wrap1", out_partial_sum, 8'd2);
    beat(2'd3, 8'd1, 8'd0, 1'b1);
    chk("wrap2", out_partial_sum, 8'd3);
    beat(2'd3, 8'd1, 8'd0, 1'b1);
    chk("wrap3", out_partial_sum, 8'd4);
    beat(2'd3, 8'd1, 8'd0, 1'b1);
    chk("wrap4", out_partial_sum, 8'd1);

    // overflow both directions, then signed 4-bit weight
    do_reset();
    load(8'd2); load(8'h0E);
    beat(2'd3, 8'd100, 8'd0, 1'b0);
`ifdef SYSTOLIC_PE_SAT_EN
    chk("ovf_pos", out_partial_sum, 8'd127);
    chk("ovf_pos_f", out_overflow, 1);
`else
    chk("ovf_pos", out_partial_sum, 8'hC8);
    chk("ovf_pos_f", out_overflow, 0);
`endif
    beat(2'd3, 8'h9C, 8'd0, 1'b1);
`ifdef SYSTOLIC_PE_SAT_EN
    chk("ovf_neg", out_partial_sum, 8'h80);
    chk("ovf_neg_f", out_overflow, 1);
`else
    chk("ovf_neg", out_partial_sum, 8'h38);
    chk("ovf_neg_f", out_overflow, 0);
`endif
    beat(2'd2, 8'd5, 8'd20, 1'b0);
    chk("m2_signed", out_partial_sum, 8'd10);
    chk("m2_ovf_clr", out_overflow, 0);

    // load and read of the same entry in one cycle
    do_reset();
    load(8'd2); load(8'd0); load(8'd0); load(8'd0);
    idle();
    en_l_b = 1; in_b = 8'd9;
    in_valid = 1; in_mode = 2'd3; in_a = 8'd3;
    step();
    chk("coll_old", out_partial_sum, 8'd6);
    beat(2'd3, 8'd3, 8'd0, 1'b0);
    chk("coll_new", out_partial_sum, 8'd27);

    // reset drops an in-flight beat
    idle(); in_valid = 1; in_mode = 2'd3; in_a = 8'd1;
    step();
    res = 1;
    step();
    chk("rst_drop_v", out_valid, 0);
    chk("rst_drop_ps", out_partial_sum, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asr, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_pe_mp.md
# systolic_pe_mp

Multi-precision, multi-depth systolic processing element, the next generation of the array PE used for matrix multiplication in convolution and hidden layers.
- Holds a bank of `Depth` weights and steps through them under `in_increment`.
- Selects weight precision (1/2/4/8-bit) per beat at runtime, so one array serves every layer precision.
- Forwards activation, weight and control down the array to avoid fan-out.
- Single cycle from operand to partial sum.

## Interface
Parameters:
- `BitSize`, 8, activation and partial-sum width (signed).
- `M_W_BitSize`, 8, weight bus width. Must be ≥ 8.
- `Depth`, 4, weight bank entries. Must be ≥ 1.
- `Offset`, 0, initial read pointer (taken modulo `Depth`).
- `FixedPointPos`, 0, arithmetic right shift applied to 4-bit and 8-bit mode products.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`, in, 1, clock.
  - `res`, in, 1, synchronous active-high reset.
- Control:
  - `in_valid`, in, 1, compute beat.
  - `in_mode`, in, 2, weight precision: 0=1b, 1=2b, 2=4b, 3=8b.
  - `en_l_b`, in, 1, write `in_b` into the bank.
  - `in_increment`, in, 1, advance the read pointer after this beat.
- Data in:
  - `in_a`, in, `BitSize`, activation.
  - `in_b`, in, `M_W_BitSize`, weight bus.
  - `in_partial_sum`, in, `BitSize`, upstream partial sum.
- Outputs:
  - `out_valid`, out, 1, registered `in_valid`.
  - `out_mode`, out, 2, registered `in_mode` (on valid).
  - `out_increment`, out, 1, registered `in_increment` (on valid).
  - `out_a`, out, `BitSize`, registered `in_a` (on valid).
  - `out_b`, out, `M_W_BitSize`, registered `in_b` (every cycle).
  - `out_l_b`, out, 1, registered `en_l_b`.
  - `out_partial_sum`, out, `BitSize`, accumulated result.
  - `out_overflow`, out, 1, saturation flag for this beat.

## Operation
- **Weight bank:** `Depth` × 8-bit entries; write pointer `wr_ptr`, read pointer `rd_ptr`.
  - `en_l_b`: `bank[wr_ptr] <= in_b[7:0]`; `wr_ptr` advances and wraps `Depth-1`→0.
  - `Depth`=1: both pointers are fixed at 0.
- **Weight decode (`w = bank[rd_ptr]`):**
  - Mode 0: `w[0]`=1 → +a; `w[0]`=0 → −a.
  - Mode 1 (ternary): `w[1:0]` 01 → +a; 11 → −a; 00/10 → 0.
  - Mode 2: `w[3:0]` signed; product = (a·w) >>> `FixedPointPos`.
  - Mode 3: `w[7:0]` signed; product = (a·w) >>> `FixedPointPos`.
- **Arithmetic:**
  - Product is computed at `BitSize`+8 bits, signed.
  - Sum = sext(`in_partial_sum`) + product, at `BitSize`+9 bits.
  - Sum is reduced to `BitSize` bits (wrap or saturate; see Configuration).
- **On `in_valid`:**
  - `out_partial_sum` <= reduced sum.
  - `out_a`, `out_mode` and `out_increment` are registered.
  - `rd_ptr` <= (`rd_ptr` + `in_increment`) mod `Depth`.
- **Without `in_valid`:** data outputs and `rd_ptr` hold.
- **`out_valid`** = `in_valid` delayed one cycle.
- **Simultaneous `en_l_b` and `in_valid` on the same entry:** the product uses the old entry value.

## Timing
- Latency is 1 cycle from `in_valid` to `out_valid`/`out_partial_sum`. No backpressure. A new beat is accepted every cycle.
- `out_b` and `out_l_b` have 1-cycle pass-through, independent of `in_valid`.
- Reset (`res`=1 at a clock edge):
  - All outputs go to 0.
  - Bank is cleared to 0.
  - `wr_ptr` goes to 0.
  - `rd_ptr` goes to `Offset` mod `Depth`.
  - Reset overrides a concurrent load or compute.
  - Reset mid-stream drops the in-flight beat: `out_valid`=0 on the next cycle.
- First beat after reset is accepted on the cycle `res` falls.

## Configuration
- `SYSTOLIC_PE_SAT_EN` defined:
  - Sum is saturated to [−2^(`BitSize`−1), 2^(`BitSize`−1)−1].
  - `out_overflow`=1 on the result cycle if clipping occurred, else 0.
- Not defined:
  - Sum is truncated (two's-complement wrap).
  - `out_overflow` is tied 0.

## Test plan
All scenarios use `BitSize`=8 and `FixedPointPos`=0.
- **Reset:** `res`=1 for 2 cycles with `in_valid`=1 → all outputs 0; first beat after release uses `bank[Offset]`.
- **8-bit mode:** load 0x03; then `in_a`=5, `in_partial_sum`=10 → next cycle `out_partial_sum`=25, `out_valid`=1, `out_a`=5.
- **Low precision:**
  - Mode 1, w=2'b11, a=7, ps=0 → 0xF9 (−7).
  - Mode 1, w=2'b10 → 0.
  - Mode 0, w=0, a=3 → −3.
- **`Depth`=4 wrap:** load 1, 2, 3, 4; five beats with a=1, ps=0, `in_increment`=1 → outputs 1, 2, 3, 4, 1.
- **Overflow:** mode 3, w=2, a=100, ps=0.
  - With the macro → 127, `out_overflow`=1.
  - Without the macro → 0xC8 (−56).
- **Load/read collision:** entry 0 holds 2; write 9 to entry 0 in the same cycle as beat a=3 → result 6; the next beat on entry 0 → 27.
